regfile_mp: RTL

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/regfile_mp.sv | 108 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// Multi-port flop register file with registered reads,
// optional write-to-read forwarding and a hardwired zero register.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 1,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  output logic                     wr_conflict
);

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic [AW-1:0]     rAddr [NUM_RD];
  logic [DATA_W-1:0] rNext [NUM_RD];
  logic [AW-1:0]     wAddr [NUM_WR];
  logic [DATA_W-1:0] wData [NUM_WR];
  logic [NUM_WR-1:0] wrOk;
  logic              conflict;

  for (genvar i = 0; i < NUM_RD; i++) begin : gRd
    assign rAddr[i] = rd_addr[i*AW +: AW];
  end

  for (genvar j = 0; j < NUM_WR; j++) begin : gWr
    assign wAddr[j] = wr_addr[j*AW +: AW];
    assign wData[j] = wr_data[j*DATA_W +: DATA_W];
  end

  // A write only counts if it lands on a real, writable register
  always_comb begin
    wrOk = '0;
    for (int j = 0; j < NUM_WR; j++) begin
      wrOk[j] = wr_en[j]
             && (int'(wAddr[j]) < NUM_REGS)
             && !(ZERO_REG != 0 && wAddr[j] == '0);
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_RD; i++) begin
      rNext[i] = '0;
      if ((int'(rAddr[i]) < NUM_REGS)
          && !(ZERO_REG != 0 && rAddr[i] == '0)) begin
        rNext[i] = mem[rAddr[i]];
        if (BYPASS != 0) begin
          for (int j = 0; j < NUM_WR; j++) begin
            if (wrOk[j] && wAddr[j] == rAddr[i]) begin
              rNext[i] = wData[j];
            end
          end
        end
      end
    end
  end

  if (NUM_WR == 2) begin : gConf
    assign conflict = wr_en[0] && wr_en[1]
                   && (wAddr[0] == wAddr[1])
                   && !(ZERO_REG != 0 && wAddr[0] == '0);
  end else begin : gNoConf
    assign conflict = 1'b0;
  end

  // Later ports overwrite earlier ones, so the highest index wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int j = 0; j < NUM_WR; j++) begin
        if (wrOk[j]) begin
          mem[wAddr[j]] <= wData[j];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data     <= '0;
      rd_valid    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      rd_valid    <= rd_en;
      wr_conflict <= conflict;
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_en[i]) begin
          rd_data[i*DATA_W +: DATA_W] <= rNext[i];
        end
      end
    end
  end

endmodule
